// File: rtl/tone_meter_pkg.sv
// tone_meter_pkg: state encoding, period width and default tone timing for tone_meter.
package tone_meter_pkg;
   localparam int PW = 32;
   typedef enum logic {ARM = 1'b0, MEASURE = 1'b1} state_t;
   localparam int unsigned DEF_CLK_HZ     = 48_000_000;
   localparam int unsigned DEF_TONE_HZ    = 1_000;
   localparam int unsigned DEF_EXP_PERIOD = DEF_CLK_HZ / DEF_TONE_HZ;
   localparam int unsigned DEF_TOL        = DEF_EXP_PERIOD / 100;
   localparam int unsigned DEF_TIMEOUT    = DEF_CLK_HZ / 100;
   localparam int unsigned DEF_LOCK_COUNT = 4;
   // lower band edge, clamped so a wide tolerance never wraps below zero
   function automatic logic [PW-1:0] band_lo(input logic [PW-1:0] exp_p, input logic [PW-1:0] tol);
      return exp_p > tol ? exp_p - tol : '0;
   endfunction
endpackage

// File: rtl/tone_meter_sync.sv
// sync_rise: two-flop synchronizer plus a history flop, emitting a registered one-cycle rise pulse.
module sync_rise (
   input  logic CLK,
   input  logic RST,
   input  logic d,
   output logic rise
);
   logic s1, s2, s3;
   always_ff @(posedge CLK) begin
      if (RST) begin
         s1   <= 1'b0;
         s2   <= 1'b0;
         s3   <= 1'b0;
         rise <= 1'b0;
      end else begin
         s1   <= d;
         s2   <= s1;
         s3   <= s2;
         rise <= s2 & ~s3;
      end
   end
endmodule

// File: rtl/tone_meter.sv
// tone_meter: measures the period of a slow square wave and flags band match, lock and tone loss.
module tone_meter
   import tone_meter_pkg::*;
#(
   parameter int unsigned CLK_HZ     = DEF_CLK_HZ,
   parameter int unsigned EXP_PERIOD = CLK_HZ / DEF_TONE_HZ,
   parameter int unsigned TOL        = EXP_PERIOD / 100,
   parameter int unsigned TIMEOUT    = CLK_HZ / 100,
   parameter int unsigned LOCK_COUNT = DEF_LOCK_COUNT
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          SIG_IN,
   output logic [PW-1:0] PERIOD,
   output logic          VALID,
   output logic          IN_BAND,
   output logic          LOCK,
   output logic          NO_TONE
);
   localparam int MW = $clog2(LOCK_COUNT + 1);
   localparam logic [PW-1:0] LO = band_lo(PW'(EXP_PERIOD), PW'(TOL));
   localparam logic [PW-1:0] HI = PW'(EXP_PERIOD + TOL);
   localparam logic [PW-1:0] TO = PW'(TIMEOUT);
   localparam logic [MW-1:0] LC = MW'(LOCK_COUNT);

   logic          rise, band;
   state_t        state;
   logic [PW-1:0] cnt, cnt_inc;
   logic [MW-1:0] match, match_nxt;

   sync_rise u_sync (.CLK(CLK), .RST(RST), .d(SIG_IN), .rise(rise));

   assign cnt_inc   = cnt + 1'b1;
   assign band      = (cnt_inc >= LO) && (cnt_inc <= HI);
   assign match_nxt = !band ? '0 : (match == LC) ? match : match + 1'b1;

   // a rise on the timeout cycle is still a measurement, so rise is tested first
   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= ARM;
         cnt     <= '0;
         match   <= '0;
         PERIOD  <= '0;
         VALID   <= 1'b0;
         IN_BAND <= 1'b0;
         LOCK    <= 1'b0;
         NO_TONE <= 1'b1;
      end else begin
         VALID <= 1'b0;
         if (state == ARM) begin
            cnt <= '0;
            if (rise) state <= MEASURE;
         end else if (rise) begin
            PERIOD  <= cnt_inc;
            VALID   <= 1'b1;
            IN_BAND <= band;
            match   <= match_nxt;
            LOCK    <= match_nxt == LC;
            NO_TONE <= 1'b0;
            cnt     <= '0;
         end else if (cnt_inc == TO) begin
            state   <= ARM;
            cnt     <= '0;
            match   <= '0;
            PERIOD  <= '0;
            IN_BAND <= 1'b0;
            LOCK    <= 1'b0;
            NO_TONE <= 1'b1;
         end else begin
            cnt <= cnt_inc;
         end
      end
   end
endmodule

// File: tb/tb_tone_meter.sv
// tb_tone_meter: directed tone stimulus with an edge-timing model checked every cycle plus literal spot checks.
`timescale 1ns/1ps
module tb_tone_meter;
   localparam int EXP = 480, TOL = 5, TMO = 4800, LC = 4;

   logic        clk = 1'b0, rst = 1'b1, sig_in = 1'b0;
   logic [31:0] period;
   logic        valid, in_band, lock, no_tone;

   tone_meter #(.CLK_HZ(48_000), .EXP_PERIOD(EXP), .TOL(TOL), .TIMEOUT(TMO), .LOCK_COUNT(LC)) dut (
      .CLK(clk), .RST(rst), .SIG_IN(sig_in), .PERIOD(period), .VALID(valid),
      .IN_BAND(in_band), .LOCK(lock), .NO_TONE(no_tone));

   always #5 clk = ~clk;

   int checks = 0, errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 40) $display("FAIL %s got %0d want %0d", name, act, exp);
      end
   endtask

   typedef struct {int p; bit ib; bit lk; bit nt; int e;} ent_t;
   ent_t vlog[$];

   // model: edges are counted; a rise sampled at edge k is acted on at edge k+3
   int  n = 0, m_last = 0, m_p = 0, m_run = 0, nt_edge = 0;
   bit  m_meas = 0, m_valid = 0, m_ib = 0, m_lk = 0, m_nt = 1, m_prev = 0, prev_nt = 0;
   int  q[$];

   always @(posedge clk) begin
      n++;
      if (rst) begin
         m_meas = 0; m_p = 0; m_valid = 0; m_ib = 0; m_lk = 0; m_nt = 1; m_run = 0; m_prev = 0;
         q.delete();
      end else begin
         m_valid = 0;
         if (q.size() > 0 && q[0] == n) begin
            void'(q.pop_front());
            if (!m_meas) begin
               m_meas = 1;
               m_last = n;
            end else begin
               m_p     = n - m_last;
               m_last  = n;
               m_valid = 1;
               m_ib    = (m_p >= EXP - TOL) && (m_p <= EXP + TOL);
               m_run   = m_ib ? ((m_run < LC) ? m_run + 1 : LC) : 0;
               m_lk    = (m_run == LC);
               m_nt    = 0;
            end
         end else if (m_meas && n - m_last == TMO) begin
            m_meas = 0; m_p = 0; m_ib = 0; m_lk = 0; m_run = 0; m_nt = 1;
         end
         if (sig_in && !m_prev) q.push_back(n + 3);
         m_prev = sig_in;
      end
      #1;
      chk("period", period, m_p);
      chk("valid", {31'd0, valid}, {31'd0, m_valid});
      chk("in_band", {31'd0, in_band}, {31'd0, m_ib});
      chk("lock", {31'd0, lock}, {31'd0, m_lk});
      chk("no_tone", {31'd0, no_tone}, {31'd0, m_nt});
      if (valid === 1'b1) vlog.push_back('{int'(period), in_band, lock, no_tone, n});
      if (no_tone === 1'b1 && !prev_nt) nt_edge = n;
      prev_nt = (no_tone === 1'b1);
   end

   time t_last = 0;

   task automatic first_rise();
      sig_in = 1'b1;
      t_last = $time;
   endtask

   task automatic next_rise(input int p);
      #(t_last + (p / 2) * 10 - $time) sig_in = 1'b0;
      #(t_last + p * 10 - $time) sig_in = 1'b1;
      t_last = $time;
   endtask

   task automatic drain();
      repeat (6) @(negedge clk);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_period"}, period, 0);
      chk({tag, "_valid"}, {31'd0, valid}, 0);
      chk({tag, "_in_band"}, {31'd0, in_band}, 0);
      chk({tag, "_lock"}, {31'd0, lock}, 0);
      chk({tag, "_no_tone"}, {31'd0, no_tone}, 1);
   endtask

   task automatic chk_ent(input string tag, input int i, input int p, input bit ib, input bit lk, input bit nt);
      if (i >= vlog.size()) begin
         chk({tag, "_present"}, vlog.size(), i + 1);
      end else begin
         chk({tag, "_p"}, vlog[i].p, p);
         chk({tag, "_ib"}, {31'd0, vlog[i].ib}, {31'd0, ib});
         chk({tag, "_lk"}, {31'd0, vlog[i].lk}, {31'd0, lk});
         chk({tag, "_nt"}, {31'd0, vlog[i].nt}, {31'd0, nt});
      end
   endtask

   int last_e;

   initial begin
      repeat (3) @(negedge clk);
      chk_reset_vals("rst");
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // 482-cycle tone: in band, lock on 4th VALID
      first_rise();
      repeat (5) next_rise(482);
      drain();
      chk("t1_count", vlog.size(), 5);
      for (int i = 0; i < 5; i++) chk_ent("t1", i, 482, 1, i >= 3, 0);
      vlog.delete();

      // 400-cycle tone, then band edges
      repeat (3) next_rise(400);
      next_rise(474); next_rise(475); next_rise(485); next_rise(486);
      drain();
      chk("t2_count", vlog.size(), 7);
      chk_ent("t2_400", 0, 400, 0, 0, 0);
      chk_ent("t2_474", 3, 474, 0, 0, 0);
      chk_ent("t2_475", 4, 475, 1, 0, 0);
      chk_ent("t2_485", 5, 485, 1, 0, 0);
      chk_ent("t2_486", 6, 486, 0, 0, 0);
      vlog.delete();

      // lock, single 500 glitch, relock
      repeat (4) next_rise(480);
      next_rise(500);
      repeat (4) next_rise(480);
      drain();
      chk("t3_count", vlog.size(), 9);
      chk_ent("t3_lock", 3, 480, 1, 1, 0);
      chk_ent("t3_glitch", 4, 500, 0, 0, 0);
      chk_ent("t3_pre", 7, 480, 1, 0, 0);
      chk_ent("t3_relock", 8, 480, 1, 1, 0);
      last_e = (vlog.size() > 0) ? vlog[vlog.size() - 1].e : 0;
      vlog.delete();

      // tone stops while locked
      #(t_last + 2400 - $time) sig_in = 1'b0;
      repeat (5000) @(negedge clk);
      chk("t4_valids", vlog.size(), 0);
      chk("t4_delay", nt_edge - last_e, TMO);
      chk("t4_period", period, 0);
      chk("t4_in_band", {31'd0, in_band}, 0);
      chk("t4_lock", {31'd0, lock}, 0);
      chk("t4_no_tone", {31'd0, no_tone}, 1);

      // rise exactly on timeout cycle, then one cycle past it
      first_rise();
      next_rise(480);
      next_rise(4800);
      next_rise(480);
      next_rise(4801);
      next_rise(480);
      drain();
      chk("t5_count", vlog.size(), 4);
      chk_ent("t5_first", 0, 480, 1, 0, 0);
      chk_ent("t5_exact", 1, 4800, 0, 0, 0);
      chk_ent("t5_after", 2, 480, 1, 0, 0);
      chk_ent("t5_rearm", 3, 480, 1, 0, 0);
      if (vlog.size() >= 3) chk("t5_to_delay", nt_edge - vlog[2].e, TMO);
      vlog.delete();

      // reset mid-period while locked
      repeat (4) next_rise(480);
      drain();
      chk("t6_locked", {31'd0, lock}, 1);
      #(t_last + 2400 - $time) sig_in = 1'b0;
      repeat (100) @(negedge clk);
      vlog.delete();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_reset_vals("t6_rst");
      repeat (100) @(negedge clk);
      first_rise();
      next_rise(480);
      drain();
      chk("t6_count", vlog.size(), 1);
      chk_ent("t6_meas", 0, 480, 1, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
